sequence_playback_ctrl: RTL
===========================

Name: sequence_playback_ctrl

Overview:
- Scheduler that plays the generated tile sequence on screen for the memory game.
- For each sequence element it requests a highlighted draw of that tile from the graphics datapath, holds the highlight for a fixed time, requests a normal-colour redraw, then waits a gap before the next element.
- Sits between the random sequence generator (source of the packed sequence) and the tile look-up/graphics datapath (consumer of tile index, colour select and draw request).
- Replaces ad-hoc delay sequencing in the top-level control FSM.

Parameters:
- SEQ_MAX, 9: maximum sequence elements; the packed sequence is 2*SEQ_MAX bits.
- FLASH_CYCLES, 25000000: clock cycles the highlighted tile stays on screen (0.5 s at 50 MHz); must be >= 1.
- GAP_CYCLES, 12500000: clock cycles between the normal redraw and the next element; must be >= 1.
- TIMER_W, 25: timer width; must hold max(FLASH_CYCLES, GAP_CYCLES) - 1.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to play; sampled only in IDLE
- seq  in  2*SEQ_MAX  packed sequence; element i is seq[2i+1:2i]
- length  in  4  number of elements to play
- draw_ack  in  1  datapath finished plotting the requested tile; one-cycle pulse
- draw_req  out  1  request the datapath to plot tile with highlight colour select
- tile  out  2  tile index of the current element
- highlight  out  1  1 = flash colour, 0 = normal colour
- index  out  4  position of the current element, 0-based
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when playback completes

Behaviour:
- States: IDLE, DRAW_ON, WAIT_ON, DRAW_OFF, WAIT_GAP, DONE. State and all outputs are registered.
- Reset (synchronous, any state, including mid-playback):
  - next state IDLE;
  - draw_req=0, tile=0, highlight=0, index=0, busy=0, done=0;
  - timer and latched sequence/length cleared.
- IDLE with start=1:
  - latch seq, and latch length clamped to SEQ_MAX.
  - latched length 0: go to DONE.
  - otherwise: go to DRAW_ON with index=0.
  - start is ignored whenever busy=1.
  - Later changes on seq/length have no effect until the next accepted start.
- DRAW_ON:
  - draw_req=1, highlight=1, tile=latched element[index].
  - Hold until draw_ack is sampled high; next cycle go to WAIT_ON with draw_req=0.
  - Latency: start sampled at cycle 0 gives draw_req=1 at cycle 1.
- WAIT_ON:
  - Timer loads FLASH_CYCLES-1 on entry and decrements each cycle.
  - On the cycle the timer reads 0, go to DRAW_OFF.
  - The state therefore lasts exactly FLASH_CYCLES cycles.
- DRAW_OFF: as DRAW_ON but highlight=0; on draw_ack go to WAIT_GAP.
- WAIT_GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - Then, if index == length-1, go to DONE.
  - Otherwise index increments and the next state is DRAW_ON with the new tile.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. tile and index hold their last values until the next start.
- draw_ack outside DRAW_ON/DRAW_OFF is ignored.
- draw_ack arriving in the first cycle of DRAW_ON/DRAW_OFF is valid: minimum draw phase is 1 cycle.
- draw_req is never deasserted before draw_ack is sampled.
- tile and highlight are stable for the whole time draw_req is high.
- Reset during DRAW_ON/DRAW_OFF drops draw_req immediately. The datapath must tolerate an abandoned plot; no ack is expected after reset.
- Width rules:
  - index compares against the clamped length (4-bit unsigned).
  - The timer never underflows: the reload happens on state entry.

Decomposition:
- Shared package: state enum (6 states, 3-bit encoding), TILE_W=2, and the 50 MHz timing constants used by the FLASH_CYCLES/GAP_CYCLES defaults.
- Sub-module playback_timer:
  - inputs: clock, reset, load, load_value[TIMER_W-1:0];
  - output: zero.
  - Down-counter reused for both WAIT_ON and WAIT_GAP.
- The FSM and sequence mux stay in sequence_playback_ctrl.

Test Plan (FLASH_CYCLES=4, GAP_CYCLES=2, draw_ack returned 3 cycles after draw_req rises unless stated):
- Reset idle: assert reset 2 cycles -> draw_req=0, busy=0, done=0, index=0, tile=0.
- Single element: seq[1:0]=2'b10, length=1, start at cycle 0:
  - cycle 1: draw_req=1, tile=2, highlight=1.
  - After the ack: 4 cycles WAIT_ON, then draw_req=1 with highlight=0.
  - After the ack: 2 cycles gap, then done=1 for one cycle.
  - Then busy=0.
- Three elements: seq low bits = 01,11,00, length=3 -> tile sequence 1,3,0; six draw requests alternating highlight 1,0; index 0,1,2; exactly one done pulse.
- length=0 and length=12 (>SEQ_MAX):
  - length=0: done one cycle after start, no draw_req.
  - length=12: plays exactly 9 elements.
- Handshake robustness:
  - stray draw_ack in WAIT_ON: no effect, timing unchanged.
  - start while busy: ignored.
  - ack in the same cycle draw_req rises: accepted, WAIT_ON begins next cycle.
- Reset mid-playback (during second element's WAIT_ON) -> next cycle IDLE, all outputs at reset values; a fresh start replays from index 0.

Source files
------------

// File: rtl/sequence_playback_ctrl_pkg.sv
// Shared types and timing constants for the tile sequence playback scheduler.
package sequence_playback_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAW_ON  = 3'd1,
    S_WAIT_ON  = 3'd2,
    S_DRAW_OFF = 3'd3,
    S_WAIT_GAP = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int TILE_W = 2;

  localparam int CLK_HZ           = 50_000_000;
  localparam int FLASH_CYCLES_50M = CLK_HZ / 2;  // 0.5 s highlight
  localparam int GAP_CYCLES_50M   = CLK_HZ / 4;  // 0.25 s between elements

endpackage

// File: rtl/playback_timer.sv
// Down-counter shared by the flash and gap waits; zero is combinational from the count.
// Load takes priority; the count saturates at zero so it can never underflow.
// No handshake: the controller reloads on every wait-state entry.
module playback_timer #(
  parameter int TIMER_W = 25
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sequence_playback_ctrl.sv
// Plays a latched tile sequence: highlighted draw, flash hold, normal redraw, gap, per element.
// Latency: start sampled in cycle 0 gives draw_req in cycle 1; all outputs registered.
// Backpressure: draw_req holds with stable tile/highlight until draw_ack is sampled.
module sequence_playback_ctrl
  import sequence_playback_ctrl_pkg::*;
#(
  parameter int SEQ_MAX      = 9,
  parameter int FLASH_CYCLES = FLASH_CYCLES_50M,
  parameter int GAP_CYCLES   = GAP_CYCLES_50M,
  parameter int TIMER_W      = 25
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2*SEQ_MAX-1:0]  seq,
  input  logic [3:0]            length,
  input  logic                  draw_ack,
  output logic                  draw_req,
  output logic [TILE_W-1:0]     tile,
  output logic                  highlight,
  output logic [3:0]            index,
  output logic                  busy,
  output logic                  done
);

  localparam logic [3:0]         SEQ_MAX_L  = 4'(SEQ_MAX);
  localparam logic [TIMER_W-1:0] FLASH_LOAD = TIMER_W'(FLASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);

  state_t                state, state_nxt;
  logic [2*SEQ_MAX-1:0]  seq_q, seq_nxt;
  logic [3:0]            len_q, len_nxt;
  logic                  draw_req_nxt, highlight_nxt, busy_nxt, done_nxt;
  logic [TILE_W-1:0]     tile_nxt;
  logic [3:0]            index_nxt;
  logic [3:0]            len_clamp, index_inc;
  logic [TILE_W-1:0]     next_elem;
  logic                  tmr_load, tmr_zero;
  logic [TIMER_W-1:0]    tmr_value;

  assign len_clamp = (length > SEQ_MAX_L) ? SEQ_MAX_L : length;
  assign index_inc = index + 4'd1;
  assign next_elem = seq_q[{index_inc, 1'b0} +: TILE_W];

  playback_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      seq_q     <= '0;
      len_q     <= '0;
      draw_req  <= 1'b0;
      tile      <= '0;
      highlight <= 1'b0;
      index     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      seq_q     <= seq_nxt;
      len_q     <= len_nxt;
      draw_req  <= draw_req_nxt;
      tile      <= tile_nxt;
      highlight <= highlight_nxt;
      index     <= index_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Outputs are computed for the state being entered, so they register alongside it.
  always_comb begin
    state_nxt     = state;
    seq_nxt       = seq_q;
    len_nxt       = len_q;
    draw_req_nxt  = draw_req;
    tile_nxt      = tile;
    highlight_nxt = highlight;
    index_nxt     = index;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    tmr_load      = 1'b0;
    tmr_value     = FLASH_LOAD;

    case (state)
      S_IDLE: begin
        busy_nxt     = 1'b0;
        draw_req_nxt = 1'b0;
        if (start) begin
          seq_nxt   = seq;
          len_nxt   = len_clamp;
          index_nxt = 4'd0;
          busy_nxt  = 1'b1;
          if (len_clamp == 4'd0) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt     = S_DRAW_ON;
            draw_req_nxt  = 1'b1;
            highlight_nxt = 1'b1;
            tile_nxt      = seq[TILE_W-1:0];
          end
        end
      end

      S_DRAW_ON: begin
        if (draw_ack) begin
          state_nxt    = S_WAIT_ON;
          draw_req_nxt = 1'b0;
          tmr_load     = 1'b1;
          tmr_value    = FLASH_LOAD;
        end
      end

      S_WAIT_ON: begin
        if (tmr_zero) begin
          state_nxt     = S_DRAW_OFF;
          draw_req_nxt  = 1'b1;
          highlight_nxt = 1'b0;
        end
      end

      S_DRAW_OFF: begin
        if (draw_ack) begin
          state_nxt    = S_WAIT_GAP;
          draw_req_nxt = 1'b0;
          tmr_load     = 1'b1;
          tmr_value    = GAP_LOAD;
        end
      end

      S_WAIT_GAP: begin
        if (tmr_zero) begin
          if (index == len_q - 4'd1) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt     = S_DRAW_ON;
            index_nxt     = index_inc;
            tile_nxt      = next_elem;
            draw_req_nxt  = 1'b1;
            highlight_nxt = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
